// File: rtl/multichannel_quadrature_nco.sv
// Multichannel quadrature NCO: one shared phase accumulator, NUM_CH offset channels,
// each producing cos/sin from a quarter-wave table, with valid/ready back-pressure.
module multichannel_quadrature_nco #(
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 8,
  parameter int DATA_W     = 24,
  parameter int NUM_CH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [PHASE_W-1:0]         fcw,
  input  logic [NUM_CH*PHASE_W-1:0]  phase_ofs,
  input  logic                       phase_clr,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [NUM_CH*DATA_W-1:0]   cos_out,
  output logic [NUM_CH*DATA_W-1:0]   sin_out,
  output logic                       wrap
);

  localparam int N = 1 << LUT_ADDR_W;
  localparam logic [LUT_ADDR_W:0] N_IDX = {1'b1, {LUT_ADDR_W{1'b0}}};

  // Elaboration-time quarter-wave entry: round(cos(k*pi/(2N)) * 2^(DATA_W-2)).
  function automatic logic signed [DATA_W-1:0] tbl_entry(input int k);
    real x, term, sum, scale;
    x = real'(k) * 3.14159265358979323846 / (2.0 * real'(N));
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    scale = 1.0;
    for (int b = 0; b < DATA_W - 2; b++) scale = scale * 2.0;
    return DATA_W'($rtoi(sum * scale + 0.5));
  endfunction

  // Table magnitude never exceeds 2^(DATA_W-2), so plain negation cannot overflow.
  function automatic logic signed [DATA_W-1:0] neg(input logic signed [DATA_W-1:0] v);
    return -v;
  endfunction

  logic signed [DATA_W-1:0] lut [N+1];
  for (genvar g = 0; g <= N; g++) begin : g_lut
    localparam logic signed [DATA_W-1:0] TV = tbl_entry(g);
    assign lut[g] = TV;
  end

  logic                        adv;
  logic [PHASE_W:0]            acc_sum;
  logic [PHASE_W-1:0]          acc_q, acc_d;
  logic                        vld_p0_q, vld_p0_d, wrap_p0_q, wrap_p0_d;
  logic [PHASE_W-1:0]          ph_p0_q, ph_p0_d;
  logic                        vld_p1_q, vld_p1_d, wrap_p1_q, wrap_p1_d;
  logic [1:0]                  quad_p1_q [NUM_CH];
  logic [1:0]                  quad_p1_d [NUM_CH];
  logic [LUT_ADDR_W-1:0]       idx_p1_q  [NUM_CH];
  logic [LUT_ADDR_W-1:0]       idx_p1_d  [NUM_CH];
  logic [LUT_ADDR_W+1:0]       top       [NUM_CH];
  logic signed [DATA_W-1:0]    t_a       [NUM_CH];
  logic signed [DATA_W-1:0]    t_b       [NUM_CH];
  logic                        out_valid_q, out_valid_d, wrap_q, wrap_d;
  logic [NUM_CH*DATA_W-1:0]    cos_q, cos_d, sin_q, sin_d;

  always_comb begin
    adv         = !out_valid_q || out_ready;
    acc_sum     = {1'b0, acc_q} + {1'b0, fcw};
    acc_d       = acc_q;
    vld_p0_d    = vld_p0_q;
    wrap_p0_d   = wrap_p0_q;
    ph_p0_d     = ph_p0_q;
    vld_p1_d    = vld_p1_q;
    wrap_p1_d   = wrap_p1_q;
    out_valid_d = out_valid_q;
    wrap_d      = wrap_q;
    cos_d       = cos_q;
    sin_d       = sin_q;

    if (phase_clr)        acc_d = '0;
    else if (en && adv)   acc_d = acc_sum[PHASE_W-1:0];

    // Stage 0: capture accumulator and carry-out of this step
    if (adv) begin
      vld_p0_d  = en;
      ph_p0_d   = acc_q;
      wrap_p0_d = en & acc_sum[PHASE_W];
      vld_p1_d  = vld_p0_q;
      wrap_p1_d = wrap_p0_q;
      out_valid_d = vld_p1_q;
      wrap_d      = vld_p1_q & wrap_p1_q;
    end

    for (int k = 0; k < NUM_CH; k++) begin
      quad_p1_d[k] = quad_p1_q[k];
      idx_p1_d[k]  = idx_p1_q[k];
      // Stage 1: offset phase, split into quadrant and truncated table index
      top[k] = (LUT_ADDR_W+2)'((ph_p0_q + phase_ofs[k*PHASE_W +: PHASE_W])
                               >> (PHASE_W - LUT_ADDR_W - 2));
      // Stage 2/3: table reads T[i], T[N-i] and quadrant sign reconstruction
      t_a[k] = lut[{1'b0, idx_p1_q[k]}];
      t_b[k] = lut[N_IDX - {1'b0, idx_p1_q[k]}];
      if (adv) begin
        quad_p1_d[k] = top[k][LUT_ADDR_W+1 -: 2];
        idx_p1_d[k]  = top[k][LUT_ADDR_W-1:0];
        case (quad_p1_q[k])
          2'd0: begin cos_d[k*DATA_W +: DATA_W] = t_a[k];      sin_d[k*DATA_W +: DATA_W] = t_b[k];      end
          2'd1: begin cos_d[k*DATA_W +: DATA_W] = neg(t_b[k]); sin_d[k*DATA_W +: DATA_W] = t_a[k];      end
          2'd2: begin cos_d[k*DATA_W +: DATA_W] = neg(t_a[k]); sin_d[k*DATA_W +: DATA_W] = neg(t_b[k]); end
          default: begin cos_d[k*DATA_W +: DATA_W] = t_b[k];   sin_d[k*DATA_W +: DATA_W] = neg(t_a[k]); end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
    end
  end

  always_ff @(posedge clk) begin
    ph_p0_q   <= ph_p0_d;
    wrap_p0_q <= wrap_p0_d;
    wrap_p1_q <= wrap_p1_d;
    quad_p1_q <= quad_p1_d;
    idx_p1_q  <= idx_p1_d;
  end

  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;

endmodule
